// File: rtl/noise_gate_stage.sv
// ---------------------------------------------------------------------------
// noise_gate_stage
//
// Gate slot of the audio FX chain. Sits between the input-gain stage and the
// EQ stage. Each incoming sample is compared against a threshold. Loud samples
// open the gate instantly at unity gain. Once the signal goes quiet, the gate
// waits for a hold period and then ramps the gain linearly down to zero.
//
// Handshake: i_sample_valid is a one-cycle strobe that qualifies i_sample_in.
// o_out_valid is a one-cycle strobe, asserted exactly one clock after each
// accepted strobe, that qualifies o_sample_out. There is no back-pressure.
// Strobes may arrive on consecutive cycles.
//
// Ports
//   i_clk          system clock
//   i_rst_n        synchronous active-low reset
//   i_sample_in    signed sample from the input-gain stage
//   i_sample_valid one-cycle strobe qualifying i_sample_in
//   i_enable       1 = gate active, 0 = bypass
//   i_thresh       threshold parameter (scaled by 2^(DATA_W-1-PARAM_W))
//   i_hold         hold parameter (HOLD_SCALE samples per LSB)
//   i_release      release parameter (extra strobes per gain step)
//   o_sample_out   gated signed sample to the EQ stage
//   o_out_valid    one-cycle strobe qualifying o_sample_out
//   o_gate_open    1 whenever the gate is not CLOSED
//   o_gate_state   CLOSED=0, OPEN=1, HOLD=2, RELEASE=3
// ---------------------------------------------------------------------------
module noise_gate_stage #(
    parameter int DATA_W     = 16,
    parameter int PARAM_W    = 7,
    parameter int HOLD_SCALE = 64,
    parameter int GAIN_W     = 9
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [DATA_W-1:0]  i_sample_in,
    input  logic               i_sample_valid,
    input  logic               i_enable,
    input  logic [PARAM_W-1:0] i_thresh,
    input  logic [PARAM_W-1:0] i_hold,
    input  logic [PARAM_W-1:0] i_release,
    output logic [DATA_W-1:0]  o_sample_out,
    output logic               o_out_valid,
    output logic               o_gate_open,
    output logic [1:0]         o_gate_state
);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPEN    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int HOLD_CNT_W = PARAM_W + $clog2(HOLD_SCALE);
    localparam int PROD_W     = DATA_W + GAIN_W + 1;
    localparam int SHIFT      = GAIN_W - 1;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = {1'b1, {SHIFT{1'b0}}};

    state_t                r_state;
    logic [GAIN_W-1:0]     r_gain;
    logic [HOLD_CNT_W-1:0] r_hold_cnt;
    logic [PARAM_W-1:0]    r_rel_div;
    logic [DATA_W-1:0]     r_sample_out;
    logic                  r_out_valid;

    state_t                w_state_nxt;
    logic [GAIN_W-1:0]     w_gain_nxt;
    logic [HOLD_CNT_W-1:0] w_hold_cnt_nxt;
    logic [PARAM_W-1:0]    w_rel_div_nxt;

    logic [DATA_W-1:0]     w_mag;
    logic [DATA_W-1:0]     w_thr;
    logic                  w_above;
    logic [HOLD_CNT_W-1:0] w_hold_load;

    logic                  w_ramp_step;
    logic [GAIN_W-1:0]     w_ramp_gain;
    logic [PARAM_W-1:0]    w_ramp_div;
    state_t                w_ramp_state;

    logic signed [PROD_W-1:0] w_sample_ext;
    logic signed [PROD_W-1:0] w_gain_ext;
    logic signed [PROD_W-1:0] w_product;
    logic [DATA_W-1:0]        w_out_nxt;
    logic                     w_unused_product;

    // Magnitude with the most negative code saturated to the largest positive.
    always_comb begin
        if (i_sample_in == {1'b1, {(DATA_W-1){1'b0}}}) begin
            w_mag = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (i_sample_in[DATA_W-1]) begin
            w_mag = (~i_sample_in) + DATA_W'(1);
        end else begin
            w_mag = i_sample_in;
        end
    end

    // Threshold parameter sits in the top magnitude bits of the sample.
    assign w_thr   = {1'b0, i_thresh, {(DATA_W-1-PARAM_W){1'b0}}};
    assign w_above = (w_mag >= w_thr);

    // Loaded on HOLD entry only; later changes to i_hold do not affect a hold
    // already in progress.
    assign w_hold_load = HOLD_CNT_W'(i_hold) * HOLD_CNT_W'(HOLD_SCALE) - HOLD_CNT_W'(1);

    // One release-ramp strobe. Using >= rather than == means that lowering
    // i_release below the running divider fires the step immediately instead
    // of letting the divider wrap. In OPEN and HOLD the divider is zero and the
    // gain is unity, so the same step also serves as the first ramp strobe.
    always_comb begin
        w_ramp_step = (r_rel_div >= i_release);
        if (w_ramp_step) begin
            w_ramp_div  = '0;
            w_ramp_gain = r_gain - GAIN_W'(1);
        end else begin
            w_ramp_div  = r_rel_div + PARAM_W'(1);
            w_ramp_gain = r_gain;
        end
        w_ramp_state = (w_ramp_gain == '0) ? ST_CLOSED : ST_RELEASE;
    end

    // Next-state logic, applied only on strobe cycles.
    always_comb begin
        w_state_nxt    = r_state;
        w_gain_nxt     = r_gain;
        w_hold_cnt_nxt = r_hold_cnt;
        w_rel_div_nxt  = r_rel_div;

        if (!i_enable || w_above) begin
            // Bypass and loud samples both snap the gate fully open.
            w_state_nxt    = ST_OPEN;
            w_gain_nxt     = GAIN_UNITY;
            w_hold_cnt_nxt = '0;
            w_rel_div_nxt  = '0;
        end else begin
            case (r_state)
                ST_OPEN: begin
                    if (i_hold == '0) begin
                        w_state_nxt   = w_ramp_state;
                        w_gain_nxt    = w_ramp_gain;
                        w_rel_div_nxt = w_ramp_div;
                    end else begin
                        w_state_nxt    = ST_HOLD;
                        w_hold_cnt_nxt = w_hold_load;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        w_state_nxt   = w_ramp_state;
                        w_gain_nxt    = w_ramp_gain;
                        w_rel_div_nxt = w_ramp_div;
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt - HOLD_CNT_W'(1);
                        w_gain_nxt     = GAIN_UNITY;
                    end
                end
                ST_RELEASE: begin
                    w_state_nxt   = w_ramp_state;
                    w_gain_nxt    = w_ramp_gain;
                    w_rel_div_nxt = w_ramp_div;
                end
                default: begin
                    w_state_nxt = ST_CLOSED;
                    w_gain_nxt  = '0;
                end
            endcase
        end
    end

    // The sample is scaled by the post-update gain so the opening sample
    // passes at unity. Gain never exceeds unity, so the floor-shifted product
    // always fits back into DATA_W bits.
    assign w_sample_ext = PROD_W'($signed(i_sample_in));
    assign w_gain_ext   = PROD_W'($signed({1'b0, w_gain_nxt}));
    assign w_product    = w_sample_ext * w_gain_ext;
    assign w_out_nxt    = i_enable ? w_product[SHIFT +: DATA_W] : i_sample_in;

    // Fractional bits and redundant sign bits of the product are dropped.
    assign w_unused_product = ^{w_product[PROD_W-1:SHIFT+DATA_W], w_product[SHIFT-1:0]};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_CLOSED;
            r_gain       <= '0;
            r_hold_cnt   <= '0;
            r_rel_div    <= '0;
            r_sample_out <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_out_valid <= i_sample_valid;
            if (i_sample_valid) begin
                r_state      <= w_state_nxt;
                r_gain       <= w_gain_nxt;
                r_hold_cnt   <= w_hold_cnt_nxt;
                r_rel_div    <= w_rel_div_nxt;
                r_sample_out <= w_out_nxt;
            end
        end
    end

    assign o_sample_out = r_sample_out;
    assign o_out_valid  = r_out_valid;
    assign o_gate_open  = (r_state != ST_CLOSED);
    assign o_gate_state = r_state;

endmodule

// File: doc/noise_gate_stage.md
Name: noise_gate_stage

Overview:
- FX slot 1 (gate) of the audio chain; sits directly downstream of the input-gain stage (FX 0) and feeds the EQ stage (FX 2).
- Consumes the gain-stage sample stream and the controller's three 7-bit gate parameters (threshold, hold, release).
- Mutes the signal when its magnitude falls below threshold, using a hold period and a linear release ramp. Opening is instantaneous.

Parameters:
- DATA_W, 16, sample width (signed two's complement)
- PARAM_W, 7, controller parameter width
- HOLD_SCALE, 64, samples of hold per hold-parameter LSB
- GAIN_W, 9, internal gain width; unity = 256

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- sample_in  in  DATA_W  signed sample from the input-gain stage
- sample_valid  in  1  one-cycle strobe, sample_in valid
- enable  in  1  1 = gate active, 0 = bypass
- thresh  in  PARAM_W  threshold param (controller default 10)
- hold  in  PARAM_W  hold param (controller default 40)
- release  in  PARAM_W  release param (controller default 5)
- sample_out  out  DATA_W  gated signed sample to EQ
- out_valid  out  1  one-cycle strobe, exactly 1 cycle after sample_valid
- gate_open  out  1  1 when state != CLOSED
- gate_state  out  2  CLOSED=0, OPEN=1, HOLD=2, RELEASE=3

Behaviour:
- Reset (rst_n low at a clk edge): state=CLOSED, gain=0, hold_cnt=0, rel_div=0, sample_out=0, out_valid=0, gate_open=0, gate_state=0. Reset mid-ramp or mid-hold abandons that operation immediately.
- All state, counter and gain updates occur only on cycles where sample_valid=1. Between strobes everything holds, and out_valid=0 except in the cycle after a strobe.
- Magnitude: mag = |sample_in|; -32768 saturates to 32767.
- Threshold: thr = thresh << (DATA_W-1-PARAM_W), i.e. thresh*256.
- Level test: above = (mag >= thr). thresh=0 therefore means the gate is always open.
- State transitions, evaluated per strobe in priority order:
  - Any state with above=1: go to OPEN, set gain=256, clear hold_cnt and rel_div.
  - OPEN with above=0: if hold=0, go to RELEASE; else go to HOLD and load hold_cnt = hold*HOLD_SCALE - 1. The hold value is latched at HOLD entry.
  - HOLD with above=0: if hold_cnt=0, go to RELEASE; else decrement hold_cnt. Gain stays 256.
  - RELEASE with above=0: rel_div increments each strobe. When rel_div == release (live value), rel_div clears and gain decrements by 1.
    - Full ramp = 256*(release+1) strobes.
    - If release drops below the current rel_div mid-ramp, the step fires on the next strobe.
    - When gain reaches 0, go to CLOSED.
  - CLOSED with above=0: remain, gain=0.
- Output, registered at the strobe edge: sample_out = (sample_in * gain_next) >>> 8.
  - gain_next is the post-update gain for this sample, so the sample that opens the gate passes at unity.
  - Product is signed DATA_W+GAIN_W+1 bits; floor via arithmetic shift; no saturation needed since gain <= 256.
  - Latency: exactly 1 clk.
- Bypass (enable=0 at a strobe): sample_out = sample_in, state forced to OPEN, gain=256, counters cleared.
  - On re-enable, the gate starts from OPEN and the first below-threshold sample enters HOLD/RELEASE per the rules above.
- Simultaneous reset and strobe: reset wins; out_valid=0.
- Back-to-back strobes (sample_valid high on consecutive cycles) are legal and each produces an out_valid.

Test Plan:
- Reset then idle: hold rst_n low 2 cycles, then release with no strobes -> all outputs 0, gate_state=0, no out_valid.
- Open/unity: thresh=10, strobe sample_in=3000 -> 1 cycle later out_valid=1, sample_out=3000, gate_state=1. Then strobe -3000 -> sample_out=-3000.
- Hold: thresh=10, hold=1, release=0; strobe 3000, then 64 strobes of 100 -> all 64 outputs = 100 with gate_state=2. The 65th strobe enters RELEASE and outputs 100*255>>>8 = 99.
- Release ramp: hold=0, release=1; after opening, strobe constant 1000 -> gain decrements every 2nd strobe. CLOSED after exactly 512 strobes, then sample_out=0 and gate_open=0.
- Re-open mid-release: during the ramp (gain≈128), strobe 5000 -> sample_out=5000, gate_state=1, rel_div cleared. Also check thresh=0 keeps the gate open on sample 0.
- Bypass and edge cases: enable=0 with gate CLOSED, strobe -32768 -> sample_out=-32768 at gate_state=1. Then assert rst_n low during RELEASE -> next cycle all outputs 0.
